rst_seq_ctrl: RTL

Power-on and run-time reset sequencer for the FPGA top level. It sits between the PLL/reset-synchronizer stage and the SoC. It waits for PLL lock, holds all subsystem resets for a programmable interval, and then releases the per-domain active-low resets one by one in index order. During run time it re-enters reset on PLL lock loss, a watchdog request or a software request, and records the cause.

---
 rtl/rst_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/rst_seq_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rst_pkg.sv
// Shared definitions for the reset sequencer: cause codes, FSM state encoding
// and a small elaboration-time helper.
package rst_pkg;

  localparam logic [1:0] RST_CAUSE_POR  = 2'd0;
  localparam logic [1:0] RST_CAUSE_LOCK = 2'd1;
  localparam logic [1:0] RST_CAUSE_SW   = 2'd2;
  localparam logic [1:0] RST_CAUSE_WDT  = 2'd3;

  // Stage index width covers the largest supported domain count (8).
  localparam int STG_W = 3;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_REL       = 2'd2,
    ST_RUN       = 2'd3
  } rst_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single-bit level signal, with a configurable
// reset value so it can be reused for signals that must reset high or low.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: waits for PLL lock, holds all domain resets for HOLD_CNT
// cycles, then releases them one per STAGE_GAP cycles; re-enters on faults.
module rst_seq_ctrl
  import rst_pkg::*;
#(
  parameter int NUM_DOMAINS = 3,
  parameter int HOLD_CNT    = 50,
  parameter int STAGE_GAP   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   pll_locked_i,
  input  logic                   sw_rst_req_i,
  input  logic                   wdt_rst_req_i,
  output logic [NUM_DOMAINS-1:0] rst_n_o,
  output logic                   busy_o,
  output logic [1:0]             rst_cause_o
);

  localparam int CNT_MAX = max_int(HOLD_CNT, STAGE_GAP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CNT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STAGE_GAP - 1);
  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(NUM_DOMAINS - 1);

  logic                   locked_s;
  rst_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [STG_W-1:0]       stage_q, stage_d;
  logic [STG_W-1:0]       stage_nxt;
  logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
  logic                   busy_q, busy_d;
  logic [1:0]             cause_q, cause_d;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (pll_locked_i),
    .q_o     (locked_s)
  );

  assign stage_nxt = stage_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    rst_n_d = rst_n_q;
    cause_d = cause_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        rst_n_d = '0;
        cnt_d   = '0;
        stage_d = '0;
        if (locked_s) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          rst_n_d = '0;
          cnt_d   = '0;
          cause_d = RST_CAUSE_LOCK;
        end else if (cnt_q == HOLD_LAST) begin
          // Stage 0 is released on the same edge that leaves HOLD.
          cnt_d   = '0;
          stage_d = '0;
          rst_n_d = NUM_DOMAINS'(1);
          state_d = (LAST_STAGE == '0) ? ST_RUN : ST_REL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REL: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          rst_n_d = '0;
          cnt_d   = '0;
          stage_d = '0;
          cause_d = RST_CAUSE_LOCK;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          stage_d = stage_nxt;
          rst_n_d = rst_n_q | (NUM_DOMAINS'(1) << stage_nxt);
          state_d = (stage_nxt == LAST_STAGE) ? ST_RUN : ST_REL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          rst_n_d = '0;
          cause_d = RST_CAUSE_LOCK;
        end else if (wdt_rst_req_i || sw_rst_req_i) begin
          state_d = ST_HOLD;
          rst_n_d = '0;
          cnt_d   = '0;
          stage_d = '0;
          cause_d = wdt_rst_req_i ? RST_CAUSE_WDT : RST_CAUSE_SW;
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        rst_n_d = '0;
      end
    endcase
    busy_d = ~&rst_n_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_WAIT_LOCK;
      cnt_q   <= '0;
      stage_q <= '0;
      rst_n_q <= '0;
      busy_q  <= 1'b1;
      cause_q <= RST_CAUSE_POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      rst_n_q <= rst_n_d;
      busy_q  <= busy_d;
      cause_q <= cause_d;
    end
  end

  assign rst_n_o     = rst_n_q;
  assign busy_o      = busy_q;
  assign rst_cause_o = cause_q;

endmodule
